// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage R2000 core: PC/IF control, bubble and flush
// generation, load-use / HI/LO / imem interlocks and exception entry/return.
module pipe_ctrl #(
  parameter int MULDIV_CYCLES = 12,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       imem_ready,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_mfhilo,
  input  logic       id_rfe,
  input  logic       br,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       muldiv_start,
  input  logic       except,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       epc_we,
  output logic       muldiv_busy,
  output logic       in_handler
);

  typedef enum logic [1:0] {
    RUN         = 2'b00,
    EXC_ENTRY   = 2'b01,
    EXC_HANDLER = 2'b10
  } state_t;

  localparam logic [1:0]       SEL_SEQ  = 2'b00;
  localparam logic [1:0]       SEL_BR   = 2'b01;
  localparam logic [1:0]       SEL_EXC  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;

  logic lu_haz_s;
  logic hl_haz_s;
  logic stall_s;
  logic exc_acc_s;

  assign lu_haz_s  = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign hl_haz_s  = busy_r && id_mfhilo;
  assign stall_s   = lu_haz_s || hl_haz_s || !imem_ready;
  // except is masked once the handler sequence has started
  assign exc_acc_s = except && (state_r == RUN);

  // Sequencer state: exception entry, handler, rfe return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (exc_acc_s) state_r <= EXC_ENTRY;
          else           state_r <= RUN;
        end
        EXC_ENTRY: state_r <= EXC_HANDLER;
        EXC_HANDLER: begin
          if (id_rfe && !stall_s) state_r <= RUN;
          else                    state_r <= EXC_HANDLER;
        end
        default: state_r <= RUN;
      endcase
    end
  end

  // HI/LO busy counter; an accepted exception abandons the operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
    end else if (exc_acc_s) begin
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
    end else if (muldiv_start) begin
      cnt_r  <= CNT_LOAD;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      if (cnt_r == {CNT_W{1'b0}}) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r  <= cnt_r;
      busy_r <= busy_r;
    end
  end

  // Per-cycle pipeline controls: exception > stall > branch > sequential
  always_comb begin
    pc_en       = 1'b1;
    pc_sel      = SEL_SEQ;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    epc_we      = 1'b0;
    if (!rst_n) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (exc_acc_s) begin
      pc_sel      = SEL_EXC;
      epc_we      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (stall_s) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (br) begin
      pc_sel = SEL_BR;
    end else begin
      pc_sel = SEL_SEQ;
    end
  end

  assign muldiv_busy = busy_r && rst_n;
  assign in_handler  = (state_r == EXC_HANDLER) && rst_n;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; outputs are packed into one vector
// {pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, exmem_flush, epc_we, muldiv_busy, in_handler}.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst_n;
  logic       imem_ready;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_mfhilo;
  logic       id_rfe;
  logic       br;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       muldiv_start;
  logic       except;
  logic       pc_en;
  logic [1:0] pc_sel;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       epc_we;
  logic       muldiv_busy;
  logic       in_handler;

  int checks_s;
  int failures_s;

  localparam logic [9:0] ZERO  = 10'b0_00_0_0_0_0_0_0_0;
  localparam logic [9:0] SEQ   = 10'b1_00_1_0_0_0_0_0_0;
  localparam logic [9:0] BRN   = 10'b1_01_1_0_0_0_0_0_0;
  localparam logic [9:0] STL   = 10'b0_00_0_0_1_0_0_0_0;
  localparam logic [9:0] EXC   = 10'b1_10_1_1_1_1_1_0_0;
  localparam logic [9:0] BUSY  = 10'b0_00_0_0_0_0_0_1_0;
  localparam logic [9:0] HAND  = 10'b0_00_0_0_0_0_0_0_1;

  pipe_ctrl #(.MULDIV_CYCLES(12), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_ready   (imem_ready),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_mfhilo    (id_mfhilo),
    .id_rfe       (id_rfe),
    .br           (br),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .muldiv_start (muldiv_start),
    .except       (except),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .epc_we       (epc_we),
    .muldiv_busy  (muldiv_busy),
    .in_handler   (in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks_s++;
    if (got !== exp) begin
      failures_s++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] exp);
    #2;
    check_val(tag, {pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, exmem_flush,
                    epc_we, muldiv_busy, in_handler}, exp);
  endtask

  task automatic quiet();
    imem_ready = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    id_mfhilo = 1'b0; id_rfe = 1'b0; br = 1'b0; ex_memread = 1'b0;
    ex_rt = 5'd0; muldiv_start = 1'b0; except = 1'b0;
  endtask

  initial begin
    checks_s = 0;
    failures_s = 0;
    quiet();
    rst_n = 1'b0;
    except = 1'b1;
    br = 1'b1;
    #2;
    chk("reset_outputs", ZERO);
    step();
    quiet();
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step(); chk("seq_idle", SEQ);
    end

    step(); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    chk("lu_rs_stall", STL);
    step(); quiet(); id_rs = 5'd8;
    chk("lu_one_bubble", SEQ);
    step(); ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    chk("lu_r0_nostall", SEQ);
    step(); quiet(); ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    chk("lu_rt_stall", STL);
    step(); id_uses_rt = 1'b0;
    chk("lu_rt_unused", SEQ);

    step(); quiet(); br = 1'b1;
    chk("br_taken", BRN);
    step(); quiet();
    chk("br_one_cycle", SEQ);
    step(); br = 1'b1; ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    chk("br_lu_stall", STL);
    step(); ex_memread = 1'b0;
    chk("br_after_stall", BRN);
    step(); quiet(); imem_ready = 1'b0;
    chk("imem_stall", STL);

    step(); quiet(); muldiv_start = 1'b1;
    chk("muldiv_start", SEQ);
    step(); muldiv_start = 1'b0; id_mfhilo = 1'b1;
    chk("hilo_stall_1", STL | BUSY);
    for (int k = 2; k <= 12; k++) begin
      step(); chk("hilo_stall", STL | BUSY);
    end
    step(); chk("hilo_release", SEQ);

    step(); quiet(); muldiv_start = 1'b1;
    chk("md_before_exc", SEQ);
    step(); except = 1'b1; imem_ready = 1'b0; id_mfhilo = 1'b1;
    chk("exc_accept", EXC | BUSY);
    step(); quiet(); id_mfhilo = 1'b1;
    chk("exc_entry", SEQ);
    step(); quiet();
    chk("exc_handler", SEQ | HAND);
    step(); except = 1'b1;
    chk("exc_masked", SEQ | HAND);
    step(); except = 1'b0;
    chk("exc_no_reentry", SEQ | HAND);
    step(); id_rfe = 1'b1; imem_ready = 1'b0;
    chk("rfe_stalled", STL | HAND);
    step(); imem_ready = 1'b1;
    chk("rfe_go", SEQ | HAND);
    step(); quiet();
    chk("rfe_back_run", SEQ);
    step(); except = 1'b1;
    chk("exc_again", EXC);
    step(); quiet();
    chk("exc_entry2", SEQ);
    step(); muldiv_start = 1'b1;
    chk("handler_md", SEQ | HAND);
    step(); muldiv_start = 1'b0;
    chk("handler_busy", SEQ | BUSY | HAND);

    #1; rst_n = 1'b0;
    #1; chk("reset_mid", ZERO);
    step(); step();
    rst_n = 1'b1;
    chk("after_reset", SEQ);
    step(); chk("after_reset_edge", SEQ);

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule
